// File: rtl/sp_ram_mbist.sv
// sp_ram_mbist: March C- self-test controller driving one single-port RAM op per cycle.
// Define SP_RAM_MBIST_CHECKERBOARD_EN to append a second pass with a 0101... background.
module sp_ram_mbist #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FAIL_DATA,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] DI,
  output logic [DATA_WIDTH-1:0] BW,
  output logic                  CE,
  output logic                  RDWEN,
  input  logic [DATA_WIDTH-1:0] DO
);
  typedef enum logic [1:0] {IDLE, MARCH, DRAIN, FINISH} state_t;
`ifdef SP_RAM_MBIST_CHECKERBOARD_EN
  localparam logic TWO_PASS = 1'b1;
`else
  localparam logic TWO_PASS = 1'b0;
`endif
  localparam logic [DATA_WIDTH-1:0] CB_PAT = DATA_WIDTH'({(DATA_WIDTH + 1) / 2{2'b01}});
  state_t state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic phase_q, phase_d, pass_q, pass_d, cmp_q, cmp_d, fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, caddr_q, caddr_d, fa_q, fa_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d, fd_q, fd_d, bg, exp_v, wdat;
  logic march, two_op, down, rd, last, step, mis;
  always_comb begin
    march  = state_q == MARCH;
    two_op = elem_q != 3'd0 && elem_q != 3'd5;
    down   = elem_q == 3'd3 || elem_q == 3'd4;
    rd     = elem_q == 3'd5 || (two_op && !phase_q);
    bg     = pass_q ? CB_PAT : '0;
    exp_v  = (elem_q == 3'd2 || elem_q == 3'd4) ? ~bg : bg;
    wdat   = (elem_q == 3'd1 || elem_q == 3'd3) ? ~bg : bg;
    last   = down ? addr_q == '0 : addr_q == '1;
    step   = !two_op || phase_q;
    mis    = cmp_q && DO != exp_q;
  end
  assign CE        = march;
  assign RDWEN     = march && !rd;
  assign A         = march ? addr_q : '0;
  assign DI        = RDWEN ? wdat : '0;
  assign BW        = '1;
  assign BUSY      = march || state_q == DRAIN;
  assign DONE      = state_q == FINISH;
  assign FAIL      = fail_q;
  assign FAIL_ADDR = fa_q;
  assign FAIL_DATA = fd_q;
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    cmp_d   = march && rd && !mis;
    exp_d   = exp_v;
    caddr_d = addr_q;
    // The op issued in the compare cycle still goes out; FINISH stops further CE.
    if (mis) begin
      state_d = FINISH;
      fail_d  = 1'b1;
      fa_d    = caddr_q;
      fd_d    = DO;
    end else if ((state_q == IDLE || state_q == FINISH) && START) begin
      state_d = MARCH;
      elem_d  = '0;
      phase_d = 1'b0;
      addr_d  = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      fa_d    = '0;
      fd_d    = '0;
    end else if (state_q == DRAIN) begin
      state_d = FINISH;
    end else if (march) begin
      phase_d = two_op && !phase_q;
      if (step) begin
        if (!last) addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
        else if (elem_q != 3'd5) begin
          elem_d = elem_q + 3'd1;
          addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? '1 : '0;
        end else if (TWO_PASS && !pass_q) begin
          elem_d = '0;
          addr_d = '0;
          pass_d = 1'b1;
        end else state_d = DRAIN;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      elem_q  <= '0;
      phase_q <= 1'b0;
      addr_q  <= '0;
      pass_q  <= 1'b0;
      cmp_q   <= 1'b0;
      exp_q   <= '0;
      caddr_q <= '0;
      fail_q  <= 1'b0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      cmp_q   <= cmp_d;
      exp_q   <= exp_d;
      caddr_q <= caddr_d;
      fail_q  <= fail_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end
endmodule

// File: tb/tb_sp_ram_mbist.sv
// tb_sp_ram_mbist: directed bench for sp_ram_mbist with a behavioural RAM and planted faults.
module tb_sp_ram_mbist;
  localparam int AW = 4, DW = 8, N = 16;
`ifdef SP_RAM_MBIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int DONE_AT = 10 * N * PASSES + 2;
  logic CLK = 0, RST = 1, START = 0;
  logic BUSY, DONE, FAIL, CE, RDWEN;
  logic [AW-1:0] FAIL_ADDR, A;
  logic [DW-1:0] FAIL_DATA, DI, BW, DO;
  logic [DW-1:0] mem [N];
  int fault = 0, cyc = 0, base = 0, n_chk = 0, n_fail = 0;
  int ce_n, wr_n, rd_n, done_rel;
  sp_ram_mbist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
    .FAIL_ADDR(FAIL_ADDR), .FAIL_DATA(FAIL_DATA), .A(A), .DI(DI), .BW(BW),
    .CE(CE), .RDWEN(RDWEN), .DO(DO)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // fault 1: bit 3 of word 5 reads stuck at 1; fault 2: writes to 9 also land on 1
  always @(posedge CLK) begin
    if (CE && RDWEN) begin
      mem[A] <= DI;
      if (fault == 2 && A == 4'd9) mem[1] <= DI;
    end else if (CE) DO <= mem[A] | ((fault == 1 && A == 4'd5) ? 8'h08 : 8'h00);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, " BUSY"}, BUSY, 0);
    check({tag, " DONE"}, DONE, 0);
    check({tag, " FAIL"}, FAIL, 0);
    check({tag, " FAIL_ADDR"}, FAIL_ADDR, 0);
    check({tag, " FAIL_DATA"}, FAIL_DATA, 0);
    check({tag, " A"}, A, 0);
    check({tag, " DI"}, DI, 0);
    check({tag, " CE"}, CE, 0);
    check({tag, " RDWEN"}, RDWEN, 0);
    check({tag, " BW"}, BW, 32'hFF);
  endtask
  task automatic start_pulse();
    @(negedge CLK);
    START = 1;
    base = cyc;
    @(negedge CLK);
    START = 0;
    ce_n = 0;
    wr_n = 0;
    rd_n = 0;
    done_rel = -1;
  endtask
  task automatic run(input bit pulses);
    int rel;
    start_pulse();
    forever begin
      rel = cyc - base;
      START = pulses && (rel == 10 || rel == 80);
      if (rel == 1) begin
        check("op0 A", A, 0);
        check("op0 DI", DI, 0);
        check("op0 RDWEN", RDWEN, 1);
        check("op0 CE", CE, 1);
        check("start BUSY", BUSY, 1);
        check("start cleared FAIL", FAIL, 0);
        check("start cleared DONE", DONE, 0);
        check("start cleared FAIL_ADDR", FAIL_ADDR, 0);
        check("start cleared FAIL_DATA", FAIL_DATA, 0);
      end
      if (rel == 2) check("op1 A", A, 1);
      if (rel == 81 && !DONE) begin
        check("M3 first A", A, 15);
        check("M3 first RDWEN", RDWEN, 0);
      end
`ifdef SP_RAM_MBIST_CHECKERBOARD_EN
      if (rel == 161 && !DONE) begin
        check("pass2 A", A, 0);
        check("pass2 DI", DI, 32'h55);
        check("pass2 RDWEN", RDWEN, 1);
      end
`else
      if (rel == 161 && !DONE) begin
        check("drain CE", CE, 0);
        check("drain BUSY", BUSY, 1);
      end
`endif
      if (CE) begin
        ce_n++;
        if (RDWEN) wr_n++;
        else rd_n++;
      end
      if (DONE) begin
        done_rel = rel;
        break;
      end
      if (rel > 400) begin
        check("DONE timeout", 0, 1);
        break;
      end
      @(negedge CLK);
    end
    START = 0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RST = 0;
    fault = 1;
    run(0);
    check("stuck FAIL", FAIL, 1);
    check("stuck FAIL_ADDR", FAIL_ADDR, 5);
    check("stuck FAIL_DATA", FAIL_DATA, 32'h08);
    check("stuck DONE cycle", done_rel, 29);
    check("stuck BUSY", BUSY, 0);
    check("stuck CE", CE, 0);
    check("stuck op count", ce_n, 28);
    fault = 0;
    run(0);
    check("pass DONE cycle", done_rel, DONE_AT);
    check("pass FAIL", FAIL, 0);
    check("pass BUSY", BUSY, 0);
    check("pass CE", CE, 0);
    check("pass op count", ce_n, 10 * N * PASSES);
    check("pass writes", wr_n, 5 * N * PASSES);
    check("pass reads", rd_n, 5 * N * PASSES);
    run(1);
    check("ignored START DONE cycle", done_rel, DONE_AT);
    check("ignored START op count", ce_n, 10 * N * PASSES);
    check("ignored START FAIL", FAIL, 0);
    fault = 2;
    run(0);
    check("alias FAIL", FAIL, 1);
    check("alias FAIL_ADDR", FAIL_ADDR, 1);
    check("alias FAIL_DATA", FAIL_DATA, 32'hFF);
    check("alias DONE cycle", done_rel, 111);
    fault = 0;
    start_pulse();
    while (cyc - base < 50) @(negedge CLK);
    check("mid BUSY", BUSY, 1);
    RST = 1;
    @(negedge CLK);
    check_reset("mid-test reset");
    RST = 0;
    run(0);
    check("after reset DONE cycle", done_rel, DONE_AT);
    check("after reset FAIL", FAIL, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
